// File: rtl/constants.sv
// Shared definitions for the load/store unit: data_format encodings and
// the FSM state type. Imported by load_store_unit and load_aligner.
package load_store_unit_pkg;

    // RISC-V funct3 encodings for memory access width/signedness
    localparam logic [2:0] FMT_B  = 3'd0;
    localparam logic [2:0] FMT_H  = 3'd1;
    localparam logic [2:0] FMT_W  = 3'd2;
    localparam logic [2:0] FMT_BU = 3'd4;
    localparam logic [2:0] FMT_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Halfwords need an even lane, words (and the unlisted formats that
    // behave as words) need lane 0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] fmt, input logic [1:0] lane);
        logic result;
        case (fmt)
            FMT_B, FMT_BU: result = 1'b0;
            FMT_H, FMT_HU: result = lane[0];
            default:       result = (lane != 2'd0);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load-data extraction: picks the addressed byte/halfword
// out of a bus word and sign- or zero-extends it. Halfwords at lane 3
// wrap around to lane 0 for their upper byte. Shared with the
// single-cycle core.
module load_aligner
    import load_store_unit_pkg::*;
(
    input  logic [31:0] bus_read_data,
    input  logic [1:0]  lane,
    input  logic [2:0]  data_format,
    output logic [31:0] result
);

    logic [1:0] next_lane;
    logic [7:0] lo_byte;
    logic [7:0] hi_byte;

    // Select the lane bytes and extend according to the access format
    always_comb begin
        next_lane = lane + 2'd1;
        lo_byte   = bus_read_data[{lane, 3'b000} +: 8];
        hi_byte   = bus_read_data[{next_lane, 3'b000} +: 8];
        case (data_format)
            FMT_B:   result = {{24{lo_byte[7]}}, lo_byte};
            FMT_BU:  result = {24'd0, lo_byte};
            FMT_H:   result = {{16{hi_byte[7]}}, hi_byte, lo_byte};
            FMT_HU:  result = {16'd0, hi_byte, lo_byte};
            default: result = bus_read_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage: accepts one load/store, runs the
// data-bus handshake with a wait-cycle timeout, and returns the extended
// load result to the write-back mux.
// Optional feature: define LSU_MISALIGNED_TRAP_EN to reject misaligned
// H/HU/W accesses with rsp_error instead of wrapping/ignoring the offset.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int WIDTH          = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               read_enable,
    input  logic               write_enable,
    input  logic [2:0]         data_format,
    input  logic [WIDTH-1:0]   address,
    input  logic [WIDTH-1:0]   write_data,
    output logic [WIDTH-1:0]   bus_address,
    output logic [WIDTH-1:0]   bus_write_data,
    output logic [3:0]         bus_byte_enable,
    output logic               bus_read_enable,
    output logic               bus_write_enable,
    input  logic               bus_ack,
    input  logic [WIDTH-1:0]   bus_read_data,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   read_data,
    output logic               rsp_error
);

    lsu_state_t  state;
    logic [1:0]  lat_lane;
    logic [2:0]  lat_fmt;
    logic [7:0]  wait_count;
    logic [7:0]  wait_next;
    logic [31:0] store_data;
    logic [3:0]  store_be;
    logic [31:0] aligned_data;
    logic        trap;

    load_aligner u_load_aligner (
        .bus_read_data (bus_read_data),
        .lane          (lat_lane),
        .data_format   (lat_fmt),
        .result        (aligned_data)
    );

    // Steer store data onto the byte lanes selected by the request address
    always_comb begin
        store_data = write_data;
        store_be   = 4'b1111;
        case (data_format)
            FMT_B, FMT_BU: begin
                store_data = {4{write_data[7:0]}};
                store_be   = 4'b0001 << address[1:0];
            end
            FMT_H, FMT_HU: begin
                store_data = {2{write_data[15:0]}};
                store_be   = 4'b0011 << address[1:0];
            end
            default: begin
                store_data = write_data;
                store_be   = 4'b1111;
            end
        endcase
    end

    // Decide whether an incoming memory request is rejected for misalignment
    always_comb begin
`ifdef LSU_MISALIGNED_TRAP_EN
        trap = (read_enable || write_enable) && is_misaligned(data_format, address[1:0]);
`else
        trap = 1'b0;
`endif
        wait_next = wait_count + 8'd1;
    end

    // Request/bus/response FSM with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            req_ready        <= 1'b1;
            bus_address      <= '0;
            bus_write_data   <= '0;
            bus_byte_enable  <= 4'd0;
            bus_read_enable  <= 1'b0;
            bus_write_enable <= 1'b0;
            rsp_valid        <= 1'b0;
            read_data        <= '0;
            rsp_error        <= 1'b0;
            wait_count       <= 8'd0;
            lat_lane         <= 2'd0;
            lat_fmt          <= FMT_B;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_lane   <= address[1:0];
                        lat_fmt    <= data_format;
                        wait_count <= 8'd0;
                        req_ready  <= 1'b0;
                        if (!(read_enable || write_enable) || trap) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            read_data <= '0;
                            rsp_error <= trap;
                        end else begin
                            state       <= BUS;
                            bus_address <= {address[WIDTH-1:2], 2'b00};
                            if (write_enable) begin
                                bus_write_enable <= 1'b1;
                                bus_write_data   <= store_data;
                                bus_byte_enable  <= store_be;
                            end else begin
                                bus_read_enable  <= 1'b1;
                                bus_write_data   <= '0;
                                bus_byte_enable  <= 4'd0;
                            end
                        end
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        read_data        <= bus_write_enable ? '0 : aligned_data;
                        rsp_error        <= 1'b0;
                        rsp_valid        <= 1'b1;
                        bus_read_enable  <= 1'b0;
                        bus_write_enable <= 1'b0;
                        bus_byte_enable  <= 4'd0;
                        state            <= RESP;
                    end else if (wait_next == TIMEOUT_CYCLES[7:0]) begin
                        read_data        <= '0;
                        rsp_error        <= 1'b1;
                        rsp_valid        <= 1'b1;
                        bus_read_enable  <= 1'b0;
                        bus_write_enable <= 1'b0;
                        bus_byte_enable  <= 4'd0;
                        wait_count       <= wait_next;
                        state            <= RESP;
                    end else begin
                        wait_count <= wait_next;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT_CYCLES=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        read_enable;
    logic        write_enable;
    logic [2:0]  data_format;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic        bus_ack;
    logic [31:0] bus_read_data;
    logic        rsp_valid;
    logic [31:0] read_data;
    logic        rsp_error;

    int vectors;
    int miscompares;

    load_store_unit #(.TIMEOUT_CYCLES(4), .WIDTH(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .read_enable      (read_enable),
        .write_enable     (write_enable),
        .data_format      (data_format),
        .address          (address),
        .write_data       (write_data),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_byte_enable  (bus_byte_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_write_enable (bus_write_enable),
        .bus_ack          (bus_ack),
        .bus_read_data    (bus_read_data),
        .rsp_valid        (rsp_valid),
        .read_data        (read_data),
        .rsp_error        (rsp_error)
    );

    // 10-time-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic issue(input logic re, input logic we, input logic [2:0] fmt,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        read_enable  = re;
        write_enable = we;
        data_format  = fmt;
        address      = addr;
        write_data   = wd;
    endtask

    task automatic test_reset;
        @(negedge clock);
        vectors++;
        if (req_ready !== 1'b1) begin
            $display("[TB] FAIL reset_ready got %b want 1", req_ready);
            miscompares++;
        end
        vectors++;
        if ({rsp_valid, rsp_error, bus_read_enable, bus_write_enable, bus_byte_enable} !== 8'd0) begin
            $display("[TB] FAIL reset_ctrl got %b want 00000000",
                     {rsp_valid, rsp_error, bus_read_enable, bus_write_enable, bus_byte_enable});
            miscompares++;
        end
        vectors++;
        if ({read_data, bus_address, bus_write_data} !== 96'd0) begin
            $display("[TB] FAIL reset_data got %h/%h/%h want zeros", read_data, bus_address, bus_write_data);
            miscompares++;
        end
        reset = 1'b0;
    endtask

    task automatic test_load_byte;
        @(negedge clock);
        issue(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0);
        @(negedge clock);
        req_valid = 1'b0;
        vectors++;
        if ({bus_read_enable, bus_write_enable, bus_byte_enable, rsp_valid, req_ready} !== 8'b1000_0000
            || bus_address !== 32'h0000_0100) begin
            $display("[TB] FAIL lb_strobe got re=%b we=%b be=%b rv=%b rdy=%b addr=%h want re=1 addr=00000100",
                     bus_read_enable, bus_write_enable, bus_byte_enable, rsp_valid, req_ready, bus_address);
            miscompares++;
        end
        bus_ack       = 1'b1;
        bus_read_data = 32'h80FF_FF7F;
        @(negedge clock);
        bus_ack = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || read_data !== 32'hFFFF_FF80 || rsp_error !== 1'b0 || bus_read_enable !== 1'b0) begin
            $display("[TB] FAIL lb_resp got rv=%b data=%h err=%b re=%b want rv=1 data=ffffff80 err=0 re=0",
                     rsp_valid, read_data, rsp_error, bus_read_enable);
            miscompares++;
        end
        @(negedge clock);
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("[TB] FAIL lb_done got rv=%b rdy=%b want rv=0 rdy=1", rsp_valid, req_ready);
            miscompares++;
        end
    endtask

    task automatic test_no_op;
        issue(1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'h0);
        @(negedge clock);
        req_valid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || read_data !== 32'h0
            || bus_read_enable !== 1'b0 || bus_write_enable !== 1'b0) begin
            $display("[TB] FAIL noop_resp got rv=%b err=%b data=%h re=%b we=%b want rv=1 err=0 data=0 re=0 we=0",
                     rsp_valid, rsp_error, read_data, bus_read_enable, bus_write_enable);
            miscompares++;
        end
        @(negedge clock);
    endtask

    task automatic test_store_half;
        issue(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            vectors++;
            if (bus_write_enable !== 1'b1 || bus_read_enable !== 1'b0 || bus_address !== 32'h0000_0200
                || bus_write_data !== 32'hABCD_ABCD || bus_byte_enable !== 4'b1100) begin
                $display("[TB] FAIL sh_bus[%0d] got we=%b re=%b addr=%h data=%h be=%b want we=1 re=0 addr=00000200 data=abcdabcd be=1100",
                         i, bus_write_enable, bus_read_enable, bus_address, bus_write_data, bus_byte_enable);
                miscompares++;
            end
        end
        bus_ack = 1'b1;
        @(negedge clock);
        bus_ack = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || bus_write_enable !== 1'b0) begin
            $display("[TB] FAIL sh_resp got rv=%b err=%b we=%b want rv=1 err=0 we=0",
                     rsp_valid, rsp_error, bus_write_enable);
            miscompares++;
        end
        @(negedge clock);
    endtask

    task automatic test_wait_states;
        issue(1'b1, 1'b0, 3'd5, 32'h0000_0000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            vectors++;
            if (bus_read_enable !== 1'b1 || bus_address !== 32'h0 || rsp_valid !== 1'b0) begin
                $display("[TB] FAIL lhu_wait[%0d] got re=%b addr=%h rv=%b want re=1 addr=0 rv=0",
                         i, bus_read_enable, bus_address, rsp_valid);
                miscompares++;
            end
            if (i == 3) begin
                bus_ack       = 1'b1;
                bus_read_data = 32'h0000_9ABC;
            end
        end
        @(negedge clock);
        bus_ack = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || read_data !== 32'h0000_9ABC || rsp_error !== 1'b0) begin
            $display("[TB] FAIL lhu_resp got rv=%b data=%h err=%b want rv=1 data=00009abc err=0",
                     rsp_valid, read_data, rsp_error);
            miscompares++;
        end
        @(negedge clock);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            $display("[TB] FAIL lhu_single_pulse got rv=%b want 0", rsp_valid);
            miscompares++;
        end
    endtask

    task automatic test_timeout;
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            vectors++;
            if (bus_read_enable !== 1'b1 || rsp_valid !== 1'b0) begin
                $display("[TB] FAIL timeout_wait[%0d] got re=%b rv=%b want re=1 rv=0", i, bus_read_enable, rsp_valid);
                miscompares++;
            end
        end
        @(negedge clock);
        vectors++;
        if (bus_read_enable !== 1'b0 || rsp_valid !== 1'b1 || rsp_error !== 1'b1 || read_data !== 32'h0) begin
            $display("[TB] FAIL timeout_resp got re=%b rv=%b err=%b data=%h want re=0 rv=1 err=1 data=0",
                     bus_read_enable, rsp_valid, rsp_error, read_data);
            miscompares++;
        end
        @(negedge clock);
    endtask

    task automatic test_misaligned;
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0005, 32'h0);
        @(negedge clock);
        req_valid = 1'b0;
`ifdef LSU_MISALIGNED_TRAP_EN
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || bus_read_enable !== 1'b0 || read_data !== 32'h0) begin
            $display("[TB] FAIL lw_trap got rv=%b err=%b re=%b data=%h want rv=1 err=1 re=0 data=0",
                     rsp_valid, rsp_error, bus_read_enable, read_data);
            miscompares++;
        end
`else
        vectors++;
        if (bus_read_enable !== 1'b1 || bus_address !== 32'h0000_0004) begin
            $display("[TB] FAIL lw_misaligned_bus got re=%b addr=%h want re=1 addr=00000004",
                     bus_read_enable, bus_address);
            miscompares++;
        end
        bus_ack       = 1'b1;
        bus_read_data = 32'h1122_3344;
        @(negedge clock);
        bus_ack = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || read_data !== 32'h1122_3344 || rsp_error !== 1'b0) begin
            $display("[TB] FAIL lw_misaligned_resp got rv=%b data=%h err=%b want rv=1 data=11223344 err=0",
                     rsp_valid, read_data, rsp_error);
            miscompares++;
        end
`endif
        @(negedge clock);
    endtask

    task automatic test_half_wrap;
`ifndef LSU_MISALIGNED_TRAP_EN
        issue(1'b1, 1'b0, 3'd1, 32'h0000_0033, 32'h0);
        @(negedge clock);
        req_valid     = 1'b0;
        bus_ack       = 1'b1;
        bus_read_data = 32'h80FF_FF7F;
        @(negedge clock);
        bus_ack = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || read_data !== 32'h0000_7F80) begin
            $display("[TB] FAIL lh_wrap got rv=%b data=%h want rv=1 data=00007f80", rsp_valid, read_data);
            miscompares++;
        end
        @(negedge clock);
`endif
    endtask

    task automatic test_store_byte_priority;
        issue(1'b1, 1'b1, 3'd0, 32'h0000_0301, 32'hFFFF_FF5A);
        @(negedge clock);
        req_valid = 1'b0;
        vectors++;
        if (bus_write_enable !== 1'b1 || bus_read_enable !== 1'b0 || bus_address !== 32'h0000_0300
            || bus_write_data !== 32'h5A5A_5A5A || bus_byte_enable !== 4'b0010) begin
            $display("[TB] FAIL sb_bus got we=%b re=%b addr=%h data=%h be=%b want we=1 re=0 addr=00000300 data=5a5a5a5a be=0010",
                     bus_write_enable, bus_read_enable, bus_address, bus_write_data, bus_byte_enable);
            miscompares++;
        end
        bus_ack = 1'b1;
        @(negedge clock);
        bus_ack = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin
            $display("[TB] FAIL sb_resp got rv=%b err=%b want rv=1 err=0", rsp_valid, rsp_error);
            miscompares++;
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0020, 32'h0);
        @(negedge clock);
        req_valid = 1'b0;
        vectors++;
        if (bus_read_enable !== 1'b1) begin
            $display("[TB] FAIL midreset_pre got re=%b want 1", bus_read_enable);
            miscompares++;
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (bus_read_enable !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("[TB] FAIL midreset_async got re=%b rdy=%b rv=%b want re=0 rdy=1 rv=0",
                     bus_read_enable, req_ready, rsp_valid);
            miscompares++;
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0008, 32'h0);
        @(negedge clock);
        req_valid = 1'b0;
        vectors++;
        if (bus_read_enable !== 1'b1 || bus_address !== 32'h0000_0008) begin
            $display("[TB] FAIL midreset_lw_bus got re=%b addr=%h want re=1 addr=00000008",
                     bus_read_enable, bus_address);
            miscompares++;
        end
        bus_ack       = 1'b1;
        bus_read_data = 32'hCAFE_F00D;
        @(negedge clock);
        bus_ack = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || read_data !== 32'hCAFE_F00D || rsp_error !== 1'b0) begin
            $display("[TB] FAIL midreset_lw_resp got rv=%b data=%h err=%b want rv=1 data=cafef00d err=0",
                     rsp_valid, read_data, rsp_error);
            miscompares++;
        end
        @(negedge clock);
    endtask

    // Run every scenario in order, then report
    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        req_valid     = 1'b0;
        read_enable   = 1'b0;
        write_enable  = 1'b0;
        data_format   = 3'd0;
        address       = 32'h0;
        write_data    = 32'h0;
        bus_ack       = 1'b0;
        bus_read_data = 32'h0;
        test_reset;
        test_load_byte;
        test_no_op;
        test_store_half;
        test_wait_states;
        test_timeout;
        test_misaligned;
        test_half_wrap;
        test_store_byte_priority;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
